// File: rtl/load_store_unit.sv
// load_store_unit
//   Single-outstanding load/store unit between EX/MEM and a 64-bit,
//   word-addressed, registered-read data memory without byte enables.
//   Sub-doubleword stores are done as read-modify-write.
//   Optional build macro: LSU_MISALIGN_CHECK_EN
//     defined   -> misaligned requests complete with resp_err=1, no memory access
//     undefined -> low address bits below the access size are cleared and the
//                  access proceeds aligned
//   The range check (word index >= MEM_WORDS) is always active.
module load_store_unit #(
  parameter int unsigned MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [63:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CAP,
    WR,
    RESP
  } state_t;

  localparam logic [63:0] MEM_WORDS_L = 64'(MEM_WORDS);

  state_t      state_q;
  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [63:0] mem_wdata_q;
  logic [63:0] resp_rdata_q;
  logic        resp_err_q;

  logic [2:0]  req_lowmask;
  logic [63:0] req_addr_al;
  logic        req_oor;
  logic        req_err;

  logic [5:0]  shamt;
  logic [63:0] ld_shift;
  logic [63:0] st_shift;
  logic [7:0]  size_lanes;
  logic [7:0]  lane_sel;
  logic [63:0] resp_rdata_d;
  logic [63:0] mem_wdata_d;

  // Request decode: alignment mask, aligned address and error classification
  always_comb begin
    req_lowmask = 3'b000;
    unique case (req_size)
      2'd0: req_lowmask = 3'b000;
      2'd1: req_lowmask = 3'b001;
      2'd2: req_lowmask = 3'b011;
      2'd3: req_lowmask = 3'b111;
      default: req_lowmask = 3'b000;
    endcase
    req_addr_al = {req_addr[63:3], req_addr[2:0] & ~req_lowmask};
    req_oor     = {3'b000, req_addr[63:3]} >= MEM_WORDS_L;
`ifdef LSU_MISALIGN_CHECK_EN
    req_err     = req_oor | (|(req_addr[2:0] & req_lowmask));
`else
    req_err     = req_oor;
`endif
  end

  // Capture-cycle datapath: load lane extraction/extension and store lane merge
  always_comb begin
    shamt      = {addr_q[2:0], 3'b000};
    ld_shift   = mem_rdata >> shamt;
    st_shift   = wdata_q << shamt;
    size_lanes = 8'h01;
    unique case (size_q)
      2'd0: size_lanes = 8'h01;
      2'd1: size_lanes = 8'h03;
      2'd2: size_lanes = 8'h0F;
      2'd3: size_lanes = 8'hFF;
      default: size_lanes = 8'h01;
    endcase
    // Offsets are always size-aligned here, so the shifted lane mask never wraps
    lane_sel = size_lanes << addr_q[2:0];

    resp_rdata_d = '0;
    unique case (size_q)
      2'd0: resp_rdata_d = uns_q ? {56'b0, ld_shift[7:0]}
                                 : {{56{ld_shift[7]}}, ld_shift[7:0]};
      2'd1: resp_rdata_d = uns_q ? {48'b0, ld_shift[15:0]}
                                 : {{48{ld_shift[15]}}, ld_shift[15:0]};
      2'd2: resp_rdata_d = uns_q ? {32'b0, ld_shift[31:0]}
                                 : {{32{ld_shift[31]}}, ld_shift[31:0]};
      2'd3: resp_rdata_d = ld_shift;
      default: resp_rdata_d = '0;
    endcase

    mem_wdata_d = mem_rdata;
    for (int unsigned k = 0; k < 8; k++) begin
      if (lane_sel[k]) begin
        mem_wdata_d[8*k +: 8] = st_shift[8*k +: 8];
      end
    end
  end

  // Control FSM with request latching and registered response/write data
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      mem_wdata_q  <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q         <= req_we;
            size_q       <= req_size;
            uns_q        <= req_unsigned;
            addr_q       <= req_addr_al;
            wdata_q      <= req_wdata;
            resp_rdata_q <= '0;
            resp_err_q   <= req_err;
            if (req_err) begin
              state_q <= RESP;
            end else if (req_we && (req_size == 2'd3)) begin
              mem_wdata_q <= req_wdata;
              state_q     <= WR;
            end else begin
              state_q <= RD;
            end
          end
        end
        RD: state_q <= CAP;
        CAP: begin
          if (we_q) begin
            mem_wdata_q <= mem_wdata_d;
            state_q     <= WR;
          end else begin
            resp_rdata_q <= resp_rdata_d;
            state_q      <= RESP;
          end
        end
        WR: state_q <= RESP;
        RESP: begin
          if (resp_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs decoded from state and latched registers; strobes suppressed on reset edges
  always_comb begin
    req_ready  = (state_q == IDLE) && !rst;
    resp_valid = (state_q == RESP);
    resp_rdata = resp_rdata_q;
    resp_err   = resp_err_q;
    mem_addr   = {3'b000, addr_q[63:3]};
    mem_wdata  = mem_wdata_q;
    mem_read   = (state_q == RD) && !rst;
    mem_write  = (state_q == WR) && !rst;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a registered-read
// 256 x 64-bit memory model (word i preloaded with i).
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_write;
  logic        mem_read;
  logic [63:0] mem_rdata;

  logic [63:0] mem [0:255];
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic [63:0] last_rd_addr = '0;

  int          n_checks = 0;
  int          n_fail = 0;

  logic [63:0] r;
  logic        e;
  int          lat, nrd, nwr, wr0;

  load_store_unit #(.MEM_WORDS(256)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_write    (mem_write),
    .mem_read     (mem_read),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: registered read, synchronous write, strobe counters
  always @(posedge clk) begin
    if (mem_read) begin
      mem_rdata    <= mem[mem_addr[7:0]];
      rd_cnt       <= rd_cnt + 1;
      last_rd_addr <= mem_addr;
    end
    if (mem_write) begin
      mem[mem_addr[7:0]] <= mem_wdata;
      wr_cnt             <= wr_cnt + 1;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request, wait (bounded) for its response and complete the handshake.
  // olat counts edges after the accept edge until resp_valid is seen.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [63:0] addr, input logic [63:0] wd,
                        output logic [63:0] ord, output logic oer,
                        output int olat, output int onrd, output int onwr);
    int rd0, wrs, w;
    rd0 = rd_cnt;
    wrs = wr_cnt;
    req_we = we; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    w = 0;
    while (!req_ready && w < 20) begin
      tick();
      w++;
    end
    tick();
    req_valid = 1'b0;
    olat = 0;
    while (!resp_valid && olat < 20) begin
      tick();
      olat++;
    end
    ord = resp_rdata;
    oer = resp_err;
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    onrd = rd_cnt - rd0;
    onwr = wr_cnt - wrs;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 64'(i);
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_rdata", resp_rdata, 64'd0);
    chk("rst_resp_err", 64'(resp_err), 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_mem_wdata", mem_wdata, 64'd0);
    chk("rst_strobes", {62'd0, mem_read, mem_write}, 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_req_ready", 64'(req_ready), 64'd1);

    // LD 0x28 -> word 5
    do_req(1'b1 ^ 1'b1, 2'd3, 1'b0, 64'h28, 64'd0, r, e, lat, nrd, nwr);
    chk("ld28_data", r, 64'd5);
    chk("ld28_err", 64'(e), 64'd0);
    chk("ld28_lat", 64'(lat), 64'd2);
    chk("ld28_reads", 64'(nrd), 64'd1);
    chk("ld28_writes", 64'(nwr), 64'd0);
    chk("ld28_mem_addr", last_rd_addr, 64'd5);

    // SD 0x10 then byte/half loads
    do_req(1'b1, 2'd3, 1'b0, 64'h10, 64'hFFFFFFFFFFFFFF80, r, e, lat, nrd, nwr);
    chk("sd10_lat", 64'(lat), 64'd1);
    chk("sd10_rw", {32'(nrd), 32'(nwr)}, {32'd0, 32'd1});
    chk("sd10_rdata", r, 64'd0);
    chk("sd10_mem", mem[2], 64'hFFFFFFFFFFFFFF80);
    do_req(1'b0, 2'd0, 1'b0, 64'h10, 64'd0, r, e, lat, nrd, nwr);
    chk("lb10", r, 64'hFFFFFFFFFFFFFF80);
    do_req(1'b0, 2'd0, 1'b1, 64'h10, 64'd0, r, e, lat, nrd, nwr);
    chk("lbu10", r, 64'h0000000000000080);
    do_req(1'b0, 2'd1, 1'b0, 64'h10, 64'd0, r, e, lat, nrd, nwr);
    chk("lh10", r, 64'hFFFFFFFFFFFFFF80);

    // Read-modify-write byte and half stores into word 0x18
    do_req(1'b1, 2'd3, 1'b0, 64'h18, 64'h1122334455667788, r, e, lat, nrd, nwr);
    chk("sd18_mem", mem[3], 64'h1122334455667788);
    do_req(1'b1, 2'd0, 1'b0, 64'h1B, 64'hAB, r, e, lat, nrd, nwr);
    chk("sb1b_lat", 64'(lat), 64'd3);
    chk("sb1b_rw", {32'(nrd), 32'(nwr)}, {32'd1, 32'd1});
    chk("sb1b_mem", mem[3], 64'h11223344AB667788);
    do_req(1'b1, 2'd1, 1'b0, 64'h1E, 64'hBEEF, r, e, lat, nrd, nwr);
    chk("sh1e_mem", mem[3], 64'hBEEF3344AB667788);
    chk("sh1e_err", 64'(e), 64'd0);
    do_req(1'b0, 2'd2, 1'b0, 64'h1C, 64'd0, r, e, lat, nrd, nwr);
    chk("lw1c", r, 64'hFFFFFFFFBEEF3344);
    do_req(1'b0, 2'd2, 1'b1, 64'h1C, 64'd0, r, e, lat, nrd, nwr);
    chk("lwu1c", r, 64'h00000000BEEF3344);

    // Misaligned word load
    do_req(1'b0, 2'd2, 1'b0, 64'h12, 64'd0, r, e, lat, nrd, nwr);
`ifdef LSU_MISALIGN_CHECK_EN
    chk("lw12_err", 64'(e), 64'd1);
    chk("lw12_rdata", r, 64'd0);
    chk("lw12_rw", {32'(nrd), 32'(nwr)}, {32'd0, 32'd0});
    chk("lw12_lat", 64'(lat), 64'd0);
`else
    chk("lw12_err", 64'(e), 64'd0);
    chk("lw12_rdata", r, 64'hFFFFFFFFFFFFFF80);
    chk("lw12_rw", {32'(nrd), 32'(nwr)}, {32'd1, 32'd0});
    chk("lw12_addr", last_rd_addr, 64'd2);
`endif

    // Range boundary: last word in range, first word out of range
    do_req(1'b1, 2'd3, 1'b0, 64'h7F8, 64'h0123456789ABCDEF, r, e, lat, nrd, nwr);
    chk("sd7f8_err", 64'(e), 64'd0);
    do_req(1'b0, 2'd3, 1'b0, 64'h7F8, 64'd0, r, e, lat, nrd, nwr);
    chk("ld7f8", r, 64'h0123456789ABCDEF);
    do_req(1'b0, 2'd3, 1'b0, 64'h800, 64'd0, r, e, lat, nrd, nwr);
    chk("ld800_err", 64'(e), 64'd1);
    chk("ld800_rdata", r, 64'd0);
    chk("ld800_lat", 64'(lat), 64'd0);
    chk("ld800_rw", {32'(nrd), 32'(nwr)}, {32'd0, 32'd0});
    do_req(1'b1, 2'd3, 1'b0, 64'h800, 64'hDEAD, r, e, lat, nrd, nwr);
    chk("sd800_err", 64'(e), 64'd1);
    chk("sd800_rw", {32'(nrd), 32'(nwr)}, {32'd0, 32'd0});

    // Response stall: LD 0x28 held 5 cycles with resp_ready low
    req_we = 1'b0; req_size = 2'd3; req_unsigned = 1'b0; req_addr = 64'h28; req_valid = 1'b1;
    chk("stall_acc_ready", 64'(req_ready), 64'd1);
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 64'(resp_valid), 64'd1);
      chk("stall_rdata", resp_rdata, 64'd5);
      chk("stall_err", 64'(resp_err), 64'd0);
      chk("stall_req_ready", 64'(req_ready), 64'd0);
      tick();
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("stall_after_valid", 64'(resp_valid), 64'd0);
    chk("stall_after_ready", 64'(req_ready), 64'd1);

    // Reset during the WR cycle of SB 0x20
    wr0 = wr_cnt;
    req_we = 1'b1; req_size = 2'd0; req_addr = 64'h20; req_wdata = 64'hFF; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("rstwr_no_write", 64'(mem_write), 64'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("rstwr_wr_cnt", 64'(wr_cnt - wr0), 64'd0);
    chk("rstwr_resp_valid", 64'(resp_valid), 64'd0);
    chk("rstwr_outs", {60'd0, mem_read, mem_write, resp_err, 1'b0}, 64'd0);
    chk("rstwr_mem_addr", mem_addr, 64'd0);
    chk("rstwr_mem_wdata", mem_wdata, 64'd0);
    chk("rstwr_resp_rdata", resp_rdata, 64'd0);
    chk("rstwr_req_ready", 64'(req_ready), 64'd1);
    chk("rstwr_mem_word", mem[4], 64'd4);
    do_req(1'b0, 2'd3, 1'b0, 64'h20, 64'd0, r, e, lat, nrd, nwr);
    chk("rstwr_readback", r, 64'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
